// File: rtl/tt_ternary_pkg.sv
// Shared definitions for the ternary weight unloader: default geometry, FSM states, invalid code.
package tt_ternary_pkg;

  localparam int DEF_MAX_IN_LEN  = 8;
  localparam int DEF_MAX_OUT_LEN = 4;
  localparam int DEF_WIDTH       = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Ternary codes are 00/01/10; all-ones is the one unused pattern.
  localparam logic [1:0] TERNARY_INVALID = 2'b11;

endpackage

// File: rtl/tt_row_check.sv
// Flags any WIDTH-bit field of a row that holds the invalid (all-ones) ternary code.
module tt_row_check
  import tt_ternary_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MAX_IN_LEN = DEF_MAX_IN_LEN
) (
  input  logic [WIDTH*MAX_IN_LEN-1:0] row,
  output logic                        err
);

  logic [MAX_IN_LEN-1:0][WIDTH-1:0] fields;
  logic [MAX_IN_LEN-1:0]            bad;

  assign fields = row;

  // All-ones generalises the 2-bit invalid code to any field width.
  for (genvar i = 0; i < MAX_IN_LEN; i++) begin : g_field
    assign bad[i] = (fields[i] == {WIDTH{1'b1}});
  end

  assign err = |bad;

endmodule

// File: rtl/tt_um_unload.sv
// Ternary weight unloader: captures a parallel weight bus and streams it out row by row, MS row first.
// Optional field check enabled by defining TERNARY_CHECK_EN.
module tt_um_unload
  import tt_ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = DEF_MAX_IN_LEN,
  parameter int MAX_OUT_LEN = DEF_MAX_OUT_LEN,
  parameter int WIDTH       = DEF_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ena,
  input  logic                                  start,
  input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
  output logic [WIDTH*MAX_IN_LEN-1:0]           uo_row,
  output logic                                  uo_valid,
  input  logic                                  ui_ready,
  output logic                                  uo_last,
  output logic                                  uo_busy,
  output logic                                  uo_err
);

  localparam int ROW_W = WIDTH * MAX_IN_LEN;
  localparam int TOT_W = ROW_W * MAX_OUT_LEN;
  localparam int CNT_W = (MAX_OUT_LEN > 1) ? $clog2(MAX_OUT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_OUT_LEN - 1);

  state_e             state;
  logic [TOT_W-1:0]   shadow;
  logic [CNT_W-1:0]   cnt;
  logic               xfer;

  assign uo_valid = (state == SEND);
  assign uo_busy  = (state == SEND);
  assign uo_last  = uo_valid && (cnt == LAST_CNT);
  assign uo_row   = shadow[TOT_W-1 -: ROW_W];
  assign xfer     = uo_valid && ui_ready && ena;

  // Shifting left keeps the next row in the MS slot; the shadow drains to zero by the end of a readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      cnt    <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= ui_weights;
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            shadow <= shadow << ROW_W;
            if (uo_last) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TERNARY_CHECK_EN
  logic row_err;

  tt_row_check #(
    .WIDTH      (WIDTH),
    .MAX_IN_LEN (MAX_IN_LEN)
  ) u_row_check (
    .row (uo_row),
    .err (row_err)
  );

  assign uo_err = uo_valid && row_err;
`else
  assign uo_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_unload.sv
// Bench for tt_um_unload: constant vector table, hand sequences, randomized run against a row-index model.
module tb_tt_um_unload;

  localparam logic [63:0] W0 = 64'h1234_5678_9ABC_DEF0;

`ifdef TERNARY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ena, start, ui_ready;
  logic [63:0] ui_weights;
  logic [15:0] uo_row;
  logic        uo_valid, uo_last, uo_busy, uo_err;

  always #5 clk = ~clk;

  tt_um_unload dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .ui_weights (ui_weights),
    .uo_row     (uo_row),
    .uo_valid   (uo_valid),
    .ui_ready   (ui_ready),
    .uo_last    (uo_last),
    .uo_busy    (uo_busy),
    .uo_err     (uo_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference: readout is "active, currently on row m_idx of captured word m_w".
  bit          m_busy;
  int          m_idx;
  logic [63:0] m_w;

  typedef struct {
    bit          rst, ena, start, ready;
    bit          valid, last;
    logic [15:0] row;
  } vec_t;
  vec_t vt[$];

  function automatic logic [15:0] slice(logic [63:0] w, int i);
    return w[63-16*i -: 16];
  endfunction

  function automatic bit has_bad(logic [15:0] r);
    for (int k = 0; k < 8; k++) if (r[2*k +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [19:0] pack_exp(bit v, bit l, logic [15:0] r);
    return {v, v, l, CHK && v && has_bad(r), r};
  endfunction

  function automatic logic [19:0] model_out();
    logic [15:0] r;
    r = m_busy ? slice(m_w, m_idx) : 16'h0;
    return pack_exp(m_busy, m_busy && (m_idx == 3), r);
  endfunction

  function automatic logic [19:0] dut_out();
    return {uo_valid, uo_busy, uo_last, uo_err, uo_row};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit e, bit s, bit rd);
    rst = r; ena = e; start = s; ui_ready = rd;
  endtask

  task automatic step();
    if (rst) begin
      m_busy = 0; m_idx = 0;
    end else if (ena) begin
      if (!m_busy && start) begin
        m_busy = 1; m_idx = 0; m_w = ui_weights;
      end else if (m_busy && ui_ready) begin
        if (m_idx == 3) m_busy = 0;
        else m_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(bit r, bit e, bit s, bit rd, bit v, bit l, logic [15:0] row);
    vec_t x;
    x.rst = r; x.ena = e; x.start = s; x.ready = rd;
    x.valid = v; x.last = l; x.row = row;
    vt.push_back(x);
  endtask

  initial begin
    logic [63:0] loader;
    bit          done;
    bit          was_last;

    m_busy = 0; m_idx = 0; m_w = '0;
    ui_weights = W0;
    drive(1, 1, 0, 0);
    step();
    step();

    // Basic readout, then idle
    add(1,1,0,0, 0,0,16'h0000);
    add(0,1,1,1, 1,0,16'h1234);
    add(0,1,0,1, 1,0,16'h5678);
    add(0,1,0,1, 1,0,16'h9ABC);
    add(0,1,0,1, 1,1,16'hDEF0);
    add(0,1,0,1, 0,0,16'h0000);
    // Backpressure on the second row
    add(0,1,1,1, 1,0,16'h1234);
    add(0,1,0,1, 1,0,16'h5678);
    add(0,1,0,0, 1,0,16'h5678);
    add(0,1,0,0, 1,0,16'h5678);
    add(0,1,0,0, 1,0,16'h5678);
    add(0,1,0,1, 1,0,16'h9ABC);
    add(0,1,0,1, 1,1,16'hDEF0);
    add(0,1,0,1, 0,0,16'h0000);
    // Enable gating mid-readout and in idle
    add(0,1,1,1, 1,0,16'h1234);
    add(0,0,0,1, 1,0,16'h1234);
    add(0,0,0,1, 1,0,16'h1234);
    add(0,1,0,1, 1,0,16'h5678);
    add(0,1,0,1, 1,0,16'h9ABC);
    add(0,1,0,1, 1,1,16'hDEF0);
    add(0,1,0,1, 0,0,16'h0000);
    add(0,0,1,1, 0,0,16'h0000);
    add(0,1,0,1, 0,0,16'h0000);
    // Start during SEND ignored; reset after the second transfer
    add(0,1,1,1, 1,0,16'h1234);
    add(0,1,1,1, 1,0,16'h5678);
    add(0,1,1,1, 1,0,16'h9ABC);
    add(1,1,0,1, 0,0,16'h0000);
    add(0,1,0,1, 0,0,16'h0000);
    // Start in the last-transfer cycle ignored
    add(0,1,1,0, 1,0,16'h1234);
    add(0,1,0,1, 1,0,16'h5678);
    add(0,1,0,1, 1,0,16'h9ABC);
    add(0,1,0,1, 1,1,16'hDEF0);
    add(0,1,1,1, 0,0,16'h0000);
    add(0,1,0,1, 0,0,16'h0000);
    // Reset wins over ena=0
    add(0,1,1,0, 1,0,16'h1234);
    add(1,0,0,0, 0,0,16'h0000);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].ena, vt[i].start, vt[i].ready);
      step();
      check($sformatf("vec%0d", i), 64'(dut_out()),
            64'(pack_exp(vt[i].valid, vt[i].last, vt[i].row)));
    end

    // Round trip through a loader that shifts each accepted row in at the LS end
    drive(0, 1, 1, 1);
    step();
    start = 0;
    loader = '0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      was_last = uo_valid && uo_last;
      if (uo_valid) loader = {loader[47:0], uo_row};
      step();
      if (was_last) done = 1;
    end
    check("roundtrip_done", 64'(done), 64'd1);
    check("roundtrip_word", loader, W0);
    check("roundtrip_idle", 64'(dut_out()), 64'(pack_exp(0, 0, 16'h0)));

    // Invalid-code row: error only while 16'h0003 is presented
    ui_weights = 64'h0000_0003_0000_0000;
    drive(0, 1, 1, 1);
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("err_row%0d", i), 64'({uo_valid, uo_err, uo_row}),
            64'({1'b1, CHK && (i == 1), slice(64'h0000_0003_0000_0000, i)}));
      step();
    end
    check("err_idle", 64'({uo_valid, uo_err}), 64'd0);

    // Randomized run against the model
    drive(1, 1, 0, 0);
    step();
    for (int n = 0; n < 600; n++) begin
      ui_weights = {$urandom, $urandom};
      rst      = ($urandom_range(0, 49) == 0);
      ena      = ($urandom_range(0, 4) != 0);
      start    = ($urandom_range(0, 3) == 0);
      ui_ready = ($urandom_range(0, 2) != 0);
      step();
      check($sformatf("rand%0d", n), 64'(dut_out()), 64'(model_out()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
